// File: rtl/traffic_light_pkg.sv
// Shared lamp codes, default dwell times and colour helpers for the traffic-light sequencer.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_GREEN  = 2'b01,
    LT_YELLOW = 2'b10,
    LT_OFF    = 2'b11
  } light_t;

  localparam int DEF_RED_CYCLES    = 8;
  localparam int DEF_GREEN_CYCLES  = 6;
  localparam int DEF_YELLOW_CYCLES = 2;
  localparam int DEF_FLASH_CYCLES  = 4;

  function automatic int dwell_for(input light_t colour, input int red, input int green,
                                   input int yellow);
    case (colour)
      LT_RED:    return red;
      LT_GREEN:  return green;
      LT_YELLOW: return yellow;
      default:   return 1;
    endcase
  endfunction

  function automatic light_t next_colour(input light_t colour);
    case (colour)
      LT_RED:    return LT_GREEN;
      LT_GREEN:  return LT_YELLOW;
      default:   return LT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Dwell counter: counts 0..limit-1 on each tick, wraps on done; clear forces it back to 0.
module tl_dwell_timer
  import traffic_light_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = tick && (count == limit - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// RED -> GREEN -> YELLOW sequencer with per-colour dwell and registered lamp code.
// Optional macro TRAFFIC_FLASH_EN: enable=0 flashes YELLOW/OFF instead of freezing.
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int FLASH_CYCLES  = DEF_FLASH_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [1:0] light
);

  localparam int MAX_RG  = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int MAX_RGY = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
  localparam int MAX_ALL = (MAX_RGY > FLASH_CYCLES) ? MAX_RGY : FLASH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  light_t           state, state_nxt, light_nxt;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count_unused;
  logic             tick, clear, done;

`ifdef TRAFFIC_FLASH_EN
  logic flash_mode, flash_mode_nxt;
  logic flash_phase, flash_phase_nxt;
`endif

  // The top keys colour changes off done; the raw count stays inside the timer.
  tl_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick),
    .limit (limit),
    .count (count_unused),
    .done  (done)
  );

  always_comb begin
    state_nxt = state;
    tick      = enable;
    clear     = 1'b0;
    limit     = CNT_W'(dwell_for(state, RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES));
`ifdef TRAFFIC_FLASH_EN
    flash_mode_nxt  = flash_mode;
    flash_phase_nxt = flash_phase;
    tick            = enable | flash_mode;
`endif
    if (state == LT_OFF) begin
      state_nxt = LT_RED;
      clear     = 1'b1;
    end
`ifdef TRAFFIC_FLASH_EN
    else if (flash_mode) begin
      limit = CNT_W'(FLASH_CYCLES);
      if (enable) begin
        flash_mode_nxt = 1'b0;
        state_nxt      = LT_RED;
        clear          = 1'b1;
      end else if (done) begin
        flash_phase_nxt = ~flash_phase;
      end
    end else if (!enable) begin
      flash_mode_nxt  = 1'b1;
      flash_phase_nxt = 1'b0;
      clear           = 1'b1;
    end
`endif
    else if (done) begin
      state_nxt = next_colour(state);
    end

    // Light is loaded with the decode of the next state so it always mirrors the register.
    light_nxt = state_nxt;
`ifdef TRAFFIC_FLASH_EN
    if (flash_mode_nxt) light_nxt = flash_phase_nxt ? LT_OFF : LT_YELLOW;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LT_RED;
      light <= 2'b00;
    end else begin
      state <= state_nxt;
      light <= light_nxt;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_mode  <= 1'b0;
      flash_phase <= 1'b0;
    end else begin
      flash_mode  <= flash_mode_nxt;
      flash_phase <= flash_phase_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm (default and TRAFFIC_FLASH_EN builds).
`timescale 1ns/100ps
module tb_traffic_light_fsm;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] light;
  logic [1:0] light_fast;
  int         checks = 0;
  int         errors = 0;

  always #1 clk = ~clk;

  traffic_light_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .light  (light)
  );

  traffic_light_fsm #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1)
  ) dut_fast (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .light  (light_fast)
  );

  // Expected colour after k enabled edges from reset with default dwells (period 16).
  function automatic logic [1:0] exp_colour(input int k);
    int m;
    m = k % 16;
    if (m < 8) return 2'b00;
    if (m < 14) return 2'b01;
    return 2'b10;
  endfunction

  // Expected flash code after j edges with enable low (j >= 1), half-period 4.
  function automatic logic [1:0] exp_flash(input int j);
    return (((j - 1) / 4) % 2 == 1) ? 2'b11 : 2'b10;
  endfunction

  task automatic cycle(input logic en);
    enable = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #0.2;
      checks++;
      if (light !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: light=%b expected 00", i, light);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cycle(1'b0);
`ifdef TRAFFIC_FLASH_EN
      exp = exp_flash(j);
`else
      exp = 2'b00;
`endif
      checks++;
      if (light !== exp) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: light=%b expected %b", j, light, exp);
      end
    end
  endtask

  task automatic test_sequence();
    apply_reset();
    checks++;
    if (light !== 2'b00) begin
      errors++;
      $display("FAIL seq_start: light=%b expected 00", light);
    end
    for (int k = 1; k <= 48; k++) begin
      cycle(1'b1);
      checks++;
      if (light !== exp_colour(k)) begin
        errors++;
        $display("FAIL seq edge %0d: light=%b expected %b", k, light, exp_colour(k));
      end
    end
  endtask

  task automatic test_pause();
    logic [1:0] exp;
    apply_reset();
    repeat (11) cycle(1'b1);
    checks++;
    if (light !== 2'b01) begin
      errors++;
      $display("FAIL pause_entry: light=%b expected 01", light);
    end
    for (int j = 1; j <= 20; j++) begin
      cycle(1'b0);
`ifdef TRAFFIC_FLASH_EN
      exp = exp_flash(j);
`else
      exp = 2'b01;
`endif
      checks++;
      if (light !== exp) begin
        errors++;
        $display("FAIL paused cycle %0d: light=%b expected %b", j, light, exp);
      end
    end
`ifdef TRAFFIC_FLASH_EN
    for (int j = 1; j <= 9; j++) begin
      cycle(1'b1);
      exp = (j <= 8) ? 2'b00 : 2'b01;
      checks++;
      if (light !== exp) begin
        errors++;
        $display("FAIL flash_restart edge %0d: light=%b expected %b", j, light, exp);
      end
    end
`else
    for (int j = 1; j <= 3; j++) begin
      cycle(1'b1);
      exp = (j <= 2) ? 2'b01 : 2'b10;
      checks++;
      if (light !== exp) begin
        errors++;
        $display("FAIL resume edge %0d: light=%b expected %b", j, light, exp);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    apply_reset();
    repeat (14) cycle(1'b1);
    checks++;
    if (light !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_pre: light=%b expected 10", light);
    end
    #0.3;
    rst = 1'b0;
    #0.1;
    checks++;
    if (light !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: light=%b expected 00", light);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (light !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_hold: light=%b expected 00", light);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1);
      exp = (k < 8) ? 2'b00 : 2'b01;
      checks++;
      if (light !== exp) begin
        errors++;
        $display("FAIL post_reset edge %0d: light=%b expected %b", k, light, exp);
      end
    end
  endtask

  task automatic test_terminal_hold();
    apply_reset();
    repeat (15) cycle(1'b1);
    checks++;
    if (light !== 2'b10) begin
      errors++;
      $display("FAIL yellow_terminal: light=%b expected 10", light);
    end
    for (int j = 1; j <= 3; j++) begin
      cycle(1'b0);
      checks++;
      if (light !== 2'b10) begin
        errors++;
        $display("FAIL terminal_hold cycle %0d: light=%b expected 10", j, light);
      end
    end
    cycle(1'b1);
    checks++;
    if (light !== 2'b00) begin
      errors++;
      $display("FAIL terminal_release: light=%b expected 00", light);
    end
  endtask

  task automatic test_fast();
    logic [1:0] exp;
    apply_reset();
    checks++;
    if (light_fast !== 2'b00) begin
      errors++;
      $display("FAIL fast_start: light=%b expected 00", light_fast);
    end
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1);
      exp = 2'(k % 3);
      checks++;
      if (light_fast !== exp) begin
        errors++;
        $display("FAIL fast edge %0d: light=%b expected %b", k, light_fast, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_pause();
    test_reset_mid();
    test_terminal_hold();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
